dds_sweep_ctrl: RTL and testbench
=================================

# dds_sweep_ctrl

Sequencer that drives the carrier phase-increment input `faza_f0` of the `dds_fm` accumulator to produce stepped-frequency sweeps (chirps or hop ladders). It latches a sweep descriptor on a start pulse and steps the frequency word a programmed number of times. Each step is held for a programmed dwell. The block also issues a one-cycle phase reset to the NCO at sweep start and reports busy/done status to the host control logic. It sits between the register bank and `dds_fm`; `faza_m` stays under modulator control and is not touched here.

## Interface
- `W`, default 32: phase-increment word width; must match `dds_fm`.
- `CW`, default 16: width of step-count and dwell fields.
- `clk`, input, 1: system clock, shared with `dds_fm`.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: single-cycle sweep request; honoured only in IDLE or DONE.
- `stop`, input, 1: single-cycle abort; honoured in any state.
- `cfg_f_start`, input, W signed: first frequency word.
- `cfg_f_step`, input, W signed: per-step increment; may be negative.
- `cfg_n_steps`, input, CW: number of frequencies in the sweep; 0 is treated as 1.
- `cfg_dwell`, input, CW: clocks each frequency is held; 0 is treated as 1.
- `cfg_repeat`, input, 1: 1 = restart from `cfg_f_start` after the last step instead of finishing.
- `faza_f0`, output, W signed: registered frequency word to `dds_fm.faza_f0`.
- `dds_rst`, output, 1: registered one-cycle pulse to `dds_fm.rst`.
- `busy`, output, 1: high in RUN.
- `done`, output, 1: one-cycle pulse when a non-repeating sweep completes.
- `step_idx`, output, CW: index of the frequency currently on `faza_f0`.

## Operation
- States: IDLE, RUN, DONE (state enum lives in the package).
- Reset values, asynchronous: state=IDLE, `faza_f0`=0, `dds_rst`=0, `busy`=0, `done`=0, `step_idx`=0, counters=0, latched config=0.
- IDLE/DONE with `start`=1:
  - Latch all `cfg_*` into shadow registers.
  - Set `faza_f0`=`cfg_f_start`, `step_idx`=0, dwell counter=1, `dds_rst`=1.
  - Go to RUN.
  - `cfg_*` changes during RUN have no effect.
- RUN:
  - Dwell counter counts 1..D, where D = max(dwell, 1).
  - When the counter reaches D and `step_idx` < N−1 (N = max(n_steps, 1)): `faza_f0` += step (two's-complement wrap mod 2^W), `step_idx`++, counter=1.
  - When the counter reaches D and `step_idx` = N−1:
    - If repeat: `faza_f0`=f_start, `step_idx`=0, counter=1, no `dds_rst`.
    - Otherwise: go to DONE, `done`=1 for one cycle, `faza_f0` holds the last word.
- DONE: outputs hold; `busy`=0; waits for `start` or `stop`.
- `stop` in any state:
  - Next state IDLE, `faza_f0`=0, `step_idx`=0, `busy`=0.
  - No `done` pulse, `dds_rst`=0.
- `start` and `stop` in the same cycle: `stop` wins.
- `start` during RUN is ignored; there is no restart mid-sweep.
- Arithmetic: the step adder is W bits, with no saturation and no overflow flag.

## Timing
- Start at edge k produces, visible after edge k: `busy`=1, `dds_rst`=1, `faza_f0`=f_start, `step_idx`=0.
- `dds_rst` is low after edge k+1. `dds_fm` therefore accumulates from 0 with f_start on its first non-reset cycle.
- Each frequency word is present on `faza_f0` for exactly D clocks.
- Non-repeating sweep length is N·D clocks from start edge to the DONE transition.
- The DONE transition occurs at edge k+N·D. After that edge: `busy`=0 and `done`=1; `done` is low after edge k+N·D+1.
- Repeat mode: the wrap back to f_start occurs at edge k+N·D and every N·D clocks thereafter.
- Stop at edge s: outputs are at their IDLE values after edge s.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `dds_ctrl_pkg` holds:
  - state enum {IDLE, RUN, DONE};
  - default width constants W=32 and CW=16;
  - a `max1` helper function for the 0→1 field rule.
- Single module with no sub-modules. The dwell and step counters are simple enough to inline.
- Top level instantiates `dds_sweep_ctrl` and `dds_fm` side by side: `faza_f0`→`faza_f0`; `dds_rst` OR system reset →`dds_fm.rst`.

## Test plan
- Reset during RUN: assert `rst` mid-sweep -> all outputs 0 immediately, without waiting for a clock; state is IDLE.
- Basic sweep: f_start=1000, step=500, n=4, dwell=3, start -> `faza_f0` = 1000, 1500, 2000, 2500, each for 3 clocks. `done` pulses at start+12; `dds_rst` is high for 1 clock after start.
- Zero fields and negative wrap:
  - f_start=0x00000010, step=−0x20, n=0, dwell=0 -> one word 0x10 for 1 clock, then `done`.
  - n=2 in the same setup -> second word 0xFFFFFFF0.
- Repeat: n=3, dwell=2, repeat=1 -> `faza_f0` sequence repeats every 6 clocks with no `done` and no further `dds_rst`. `stop` -> `faza_f0`=0 and `busy`=0 after the next edge.
- Collisions: `start` during RUN is ignored and the sequence is unchanged. `start`+`stop` in the same cycle from IDLE -> stays IDLE with no `dds_rst`.
- Config isolation and DONE restart:
  - Change `cfg_f_step` mid-sweep -> the running sequence is unaffected.
  - `start` from DONE -> new sweep with fresh config and a new `dds_rst` pulse.

Source files
------------

// File: rtl/dds_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dds_ctrl_pkg
// Shared definitions for the DDS sweep controller:
//   - state_t     : sweep sequencer states (IDLE, RUN, DONE)
//   - DDS_W       : default phase-increment word width (matches dds_fm)
//   - DDS_CW      : default width of the step-count and dwell fields
//   - max1()      : maps a zero-valued count field to 1
// ---------------------------------------------------------------------------
package dds_ctrl_pkg;

    localparam int DDS_W  = 32;
    localparam int DDS_CW = 16;

    // Wide enough for any count field this package is expected to serve.
    localparam int MAX1_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A programmed count of zero behaves as one.
    function automatic logic [MAX1_W-1:0] max1(input logic [MAX1_W-1:0] v);
        return (v == '0) ? MAX1_W'(1) : v;
    endfunction

endpackage

// File: rtl/dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// dds_sweep_ctrl
// Stepped-frequency sweep sequencer driving dds_fm.faza_f0.
// A start pulse latches a sweep descriptor and then walks the frequency word
// from f_start in f_step increments, holding each word for `dwell` clocks,
// for `n_steps` words. Optionally repeats forever. A one-cycle NCO phase
// reset is issued at sweep start.
//
// Ports:
//   clk          system clock (shared with dds_fm)
//   rst          asynchronous active-high reset
//   start        single-cycle sweep request (IDLE/DONE only)
//   stop         single-cycle abort (any state, wins over start)
//   cfg_f_start  first frequency word (signed, W)
//   cfg_f_step   per-step increment (signed, W, may be negative)
//   cfg_n_steps  number of words in the sweep (0 treated as 1)
//   cfg_dwell    clocks per word (0 treated as 1)
//   cfg_repeat   restart from f_start after the last word
//   faza_f0      registered frequency word to dds_fm
//   dds_rst      registered one-cycle pulse to dds_fm.rst
//   busy         high while sweeping
//   done         one-cycle pulse on completion of a non-repeating sweep
//   step_idx     index of the word currently on faza_f0
// ---------------------------------------------------------------------------
module dds_sweep_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int W  = DDS_W,
    parameter int CW = DDS_CW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic signed [W-1:0] cfg_f_start,
    input  logic signed [W-1:0] cfg_f_step,
    input  logic [CW-1:0]       cfg_n_steps,
    input  logic [CW-1:0]       cfg_dwell,
    input  logic                cfg_repeat,
    output logic signed [W-1:0] faza_f0,
    output logic                dds_rst,
    output logic                busy,
    output logic                done,
    output logic [CW-1:0]       step_idx
);

    state_t state, state_nx;

    // Shadow copy of the descriptor, frozen for the duration of a sweep.
    logic signed [W-1:0] sh_f_start, sh_f_step;
    logic [CW-1:0]       sh_n_steps, sh_dwell;
    logic                sh_repeat;

    logic [CW-1:0]       dwell_cnt;

    // Next-cycle values of every register.
    logic signed [W-1:0] sh_f_start_nx, sh_f_step_nx;
    logic [CW-1:0]       sh_n_steps_nx, sh_dwell_nx;
    logic                sh_repeat_nx;
    logic [CW-1:0]       dwell_cnt_nx;
    logic signed [W-1:0] faza_f0_nx;
    logic                dds_rst_nx, busy_nx, done_nx;
    logic [CW-1:0]       step_idx_nx;

    // Effective dwell length and index of the last word (N-1, N >= 1).
    logic [CW-1:0] dwell_lim, last_idx;

    assign dwell_lim = CW'(max1(MAX1_W'(sh_dwell)));
    assign last_idx  = CW'(max1(MAX1_W'(sh_n_steps))) - CW'(1);

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nx      = state;
        sh_f_start_nx = sh_f_start;
        sh_f_step_nx  = sh_f_step;
        sh_n_steps_nx = sh_n_steps;
        sh_dwell_nx   = sh_dwell;
        sh_repeat_nx  = sh_repeat;
        dwell_cnt_nx  = dwell_cnt;
        faza_f0_nx    = faza_f0;
        step_idx_nx   = step_idx;
        busy_nx       = busy;
        dds_rst_nx    = 1'b0;   // pulses: low unless explicitly raised
        done_nx       = 1'b0;

        if (stop) begin
            state_nx     = IDLE;
            faza_f0_nx   = '0;
            step_idx_nx  = '0;
            dwell_cnt_nx = '0;
            busy_nx      = 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sh_f_start_nx = cfg_f_start;
                        sh_f_step_nx  = cfg_f_step;
                        sh_n_steps_nx = cfg_n_steps;
                        sh_dwell_nx   = cfg_dwell;
                        sh_repeat_nx  = cfg_repeat;
                        faza_f0_nx    = cfg_f_start;
                        step_idx_nx   = '0;
                        dwell_cnt_nx  = CW'(1);
                        dds_rst_nx    = 1'b1;
                        busy_nx       = 1'b1;
                        state_nx      = RUN;
                    end
                end

                RUN: begin
                    if (dwell_cnt >= dwell_lim) begin
                        if (step_idx < last_idx) begin
                            // Plain W-bit add: wraps modulo 2^W by design.
                            faza_f0_nx   = faza_f0 + sh_f_step;
                            step_idx_nx  = step_idx + CW'(1);
                            dwell_cnt_nx = CW'(1);
                        end else if (sh_repeat) begin
                            // Wrap without a phase reset: the NCO stays continuous.
                            faza_f0_nx   = sh_f_start;
                            step_idx_nx  = '0;
                            dwell_cnt_nx = CW'(1);
                        end else begin
                            // Last word stays on faza_f0 through DONE.
                            busy_nx  = 1'b0;
                            done_nx  = 1'b1;
                            state_nx = DONE;
                        end
                    end else begin
                        dwell_cnt_nx = dwell_cnt + CW'(1);
                    end
                end

                default: state_nx = IDLE;
            endcase
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge
    // values; blocking ones here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sh_f_start <= '0;
            sh_f_step  <= '0;
            sh_n_steps <= '0;
            sh_dwell   <= '0;
            sh_repeat  <= 1'b0;
            dwell_cnt  <= '0;
            faza_f0    <= '0;
            dds_rst    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            step_idx   <= '0;
        end else begin
            state      <= state_nx;
            sh_f_start <= sh_f_start_nx;
            sh_f_step  <= sh_f_step_nx;
            sh_n_steps <= sh_n_steps_nx;
            sh_dwell   <= sh_dwell_nx;
            sh_repeat  <= sh_repeat_nx;
            dwell_cnt  <= dwell_cnt_nx;
            faza_f0    <= faza_f0_nx;
            dds_rst    <= dds_rst_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            step_idx   <= step_idx_nx;
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dds_sweep_ctrl
// Directed scoreboard bench for dds_sweep_ctrl. The stimulus process drives
// inputs on the falling edge and queues the hand-computed output snapshot
// expected after the next rising edge; the monitor pops one snapshot per
// rising edge (sampled #1 later) and compares.
// ---------------------------------------------------------------------------
module tb_dds_sweep_ctrl;
    import dds_ctrl_pkg::*;

    localparam int W  = 32;
    localparam int CW = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                stop = 1'b0;
    logic signed [W-1:0] cfg_f_start = '0;
    logic signed [W-1:0] cfg_f_step = '0;
    logic [CW-1:0]       cfg_n_steps = '0;
    logic [CW-1:0]       cfg_dwell = '0;
    logic                cfg_repeat = 1'b0;
    logic signed [W-1:0] faza_f0;
    logic                dds_rst;
    logic                busy;
    logic                done;
    logic [CW-1:0]       step_idx;

    dds_sweep_ctrl #(.W(W), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .cfg_f_start (cfg_f_start),
        .cfg_f_step  (cfg_f_step),
        .cfg_n_steps (cfg_n_steps),
        .cfg_dwell   (cfg_dwell),
        .cfg_repeat  (cfg_repeat),
        .faza_f0     (faza_f0),
        .dds_rst     (dds_rst),
        .busy        (busy),
        .done        (done),
        .step_idx    (step_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  f;
        logic          r;
        logic          b;
        logic          d;
        logic [CW-1:0] i;
    } snap_t;

    snap_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One clock of stimulus plus the snapshot expected after its rising edge.
    task automatic tick(input logic s, input logic p, input logic [W-1:0] f,
                        input logic r, input logic b, input logic d, input logic [CW-1:0] i);
        snap_t e;
        @(negedge clk);
        start = s;
        stop  = p;
        e.f = f; e.r = r; e.b = b; e.d = d; e.i = i;
        exp_q.push_back(e);
    endtask

    // n further clocks of a running word, no control inputs.
    task automatic hold(input logic [W-1:0] f, input logic [CW-1:0] i, input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, f, 1'b0, 1'b1, 1'b0, i);
    endtask

    task automatic set_cfg(input logic [W-1:0] fs, input logic [W-1:0] st,
                           input logic [CW-1:0] n, input logic [CW-1:0] dw, input logic rp);
        cfg_f_start = fs;
        cfg_f_step  = st;
        cfg_n_steps = n;
        cfg_dwell   = dw;
        cfg_repeat  = rp;
    endtask

    // Monitor: the DUT presents a new snapshot after every rising edge.
    initial begin
        snap_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.f = faza_f0; a.r = dds_rst; a.b = busy; a.d = done; a.i = step_idx;
                check("snapshot {faza_f0,dds_rst,busy,done,step_idx}", 64'(a), 64'(e));
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        #1 check("reset faza_f0", 64'(faza_f0), 64'd0);
        rst = 1'b0;
        tick(0, 0, 32'd0, 0, 0, 0, 0);

        // Basic sweep, with a mid-sweep config change and an ignored start.
        set_cfg(32'd1000, 32'd500, 16'd4, 16'd3, 1'b0);
        tick(1, 0, 32'd1000, 1, 1, 0, 0);
        hold(32'd1000, 0, 2);
        hold(32'd1500, 1, 1);
        cfg_f_step  = 32'd7;               // must not affect the running sweep
        cfg_f_start = 32'd99;
        tick(1, 0, 32'd1500, 0, 1, 0, 1);  // start in RUN: ignored
        hold(32'd1500, 1, 1);
        hold(32'd2000, 2, 3);
        hold(32'd2500, 3, 3);
        tick(0, 0, 32'd2500, 0, 0, 1, 3);  // edge k+12: DONE
        tick(0, 0, 32'd2500, 0, 0, 0, 3);
        tick(0, 0, 32'd2500, 0, 0, 0, 3);

        // Restart from DONE with fresh config: zero fields, single word.
        set_cfg(32'h0000_0010, -32'sh20, 16'd0, 16'd0, 1'b0);
        tick(1, 0, 32'h0000_0010, 1, 1, 0, 0);
        tick(0, 0, 32'h0000_0010, 0, 0, 1, 0);
        tick(0, 0, 32'h0000_0010, 0, 0, 0, 0);

        // Two words, negative step wraps below zero.
        cfg_n_steps = 16'd2;
        tick(1, 0, 32'h0000_0010, 1, 1, 0, 0);
        tick(0, 0, 32'hFFFF_FFF0, 0, 1, 0, 1);
        tick(0, 0, 32'hFFFF_FFF0, 0, 0, 1, 1);
        tick(0, 0, 32'hFFFF_FFF0, 0, 0, 0, 1);

        // Stop from DONE returns to IDLE values.
        tick(0, 1, 32'd0, 0, 0, 0, 0);

        // Repeat mode: period 6, no done, no further dds_rst, then stop.
        set_cfg(32'd100, 32'd10, 16'd3, 16'd2, 1'b1);
        tick(1, 0, 32'd100, 1, 1, 0, 0);
        hold(32'd100, 0, 1);
        for (int p = 0; p < 2; p++) begin
            hold(32'd110, 1, 2);
            hold(32'd120, 2, 2);
            hold(32'd100, 0, 2);
        end
        tick(0, 1, 32'd0, 0, 0, 0, 0);
        tick(0, 0, 32'd0, 0, 0, 0, 0);

        // start + stop together from IDLE: stop wins.
        tick(1, 1, 32'd0, 0, 0, 0, 0);
        tick(0, 0, 32'd0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a sweep.
        set_cfg(32'd1000, 32'd500, 16'd4, 16'd3, 1'b0);
        tick(1, 0, 32'd1000, 1, 1, 0, 0);
        hold(32'd1000, 0, 2);
        hold(32'd1500, 1, 1);
        @(negedge clk);
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async rst faza_f0",  64'(faza_f0), 64'd0);
        check("async rst step_idx", 64'(step_idx), 64'd0);
        check("async rst busy/done/dds_rst", 64'({busy, done, dds_rst}), 64'd0);
        check("async rst state", 64'(dut.state), 64'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        tick(0, 0, 32'd0, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
